// File: rtl/aes_key_pkg.sv
// Shared constants, types and helpers for the AES-256 key schedule writer.
// S-box, Rcon, default BRAM layout and the writer state encoding.
package aes_key_pkg;

  localparam int NWORDS_DEF   = 60;
  localparam int ENC_BASE_DEF = 0;
  localparam int DEC_BASE_DEF = 60;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    FIN
  } state_t;

  // Index 0 is unused; entries past 10 are never reached by AES-256.
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// SubWord: four parallel combinational AES S-box lookups.
// Pure lookup, no state.
module aes_sbox_word
  import aes_key_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  assign o_word = {
    SBOX[i_word[31:24]],
    SBOX[i_word[23:16]],
    SBOX[i_word[15:8]],
    SBOX[i_word[7:0]]
  };

endmodule

// File: rtl/key_sched_bram_writer.sv
// AES-256 key expansion into the key BRAM write port, one word per write.
// Define DEC_KEY_SCHED_EN to also write the round-reversed decrypt schedule.
module key_sched_bram_writer
  import aes_key_pkg::*;
#(
  parameter int NWORDS   = NWORDS_DEF,
  parameter int ENC_BASE = ENC_BASE_DEF,
  parameter int DEC_BASE = DEC_BASE_DEF,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [255:0]      key_in,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_wdata,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = $clog2(NWORDS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NWORDS - 1);

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [31:0]       r_win [8];
  logic [31:0]       w_win_nxt [8];
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [31:0]       r_wdata, w_wdata_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;

  logic [31:0] w_sb_in;
  logic [31:0] w_sb_out;
  logic [31:0] w_t;
  logic [31:0] w_new;
  logic [3:0]  w_rc_idx;

  // Window holds w[i..i+7]; the word shifted in is w[i+8].
  assign w_sb_in = (r_idx[2:0] == 3'd0) ?
                   rot_word(r_win[7]) : r_win[7];

  aes_sbox_word u_sbox (
    .i_word (w_sb_in),
    .o_word (w_sb_out)
  );

  assign w_rc_idx = 4'(r_idx >> 3) + 4'd1;

  always_comb begin
    w_t = r_win[7];
    unique case (1'b1)
      (r_idx[2:0] == 3'd0): w_t = w_sb_out ^ {RCON[w_rc_idx], 24'h0};
      (r_idx[2:0] == 3'd4): w_t = w_sb_out;
      default: ;
    endcase
  end

  assign w_new = r_win[0] ^ w_t;

`ifdef DEC_KEY_SCHED_EN
  logic              r_ph, w_ph_nxt;
  logic [ADDR_W-1:0] w_dec_addr;

  assign w_dec_addr = ADDR_W'(DEC_BASE
                    + 4 * (NWORDS / 4 - 1 - int'(r_idx >> 2))
                    + int'(r_idx[1:0]));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ph <= 1'b0;
    else      r_ph <= w_ph_nxt;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_win_nxt   = r_win;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
`ifdef DEC_KEY_SCHED_EN
    w_ph_nxt    = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = EXPAND;
          w_idx_nxt   = '0;
          for (int k = 0; k < 8; k++)
            w_win_nxt[k] = key_in[255-32*k -: 32];
          w_we_nxt    = 1'b1;
          w_addr_nxt  = ADDR_W'(ENC_BASE);
          w_wdata_nxt = key_in[255:224];
          w_busy_nxt  = 1'b1;
        end
      end
      EXPAND: begin
`ifdef DEC_KEY_SCHED_EN
        if (!r_ph) begin
          w_ph_nxt   = 1'b1;
          w_we_nxt   = 1'b1;
          w_addr_nxt = w_dec_addr;
        end else
`endif
        if (r_idx == LAST) begin
          w_state_nxt = FIN;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
          for (int k = 0; k < 7; k++)
            w_win_nxt[k] = r_win[k+1];
          w_win_nxt[7] = w_new;
          w_we_nxt     = 1'b1;
          w_addr_nxt   = ADDR_W'(ENC_BASE + int'(r_idx) + 1);
          w_wdata_nxt  = r_win[1];
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_win   <= '{default: '0};
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_win   <= w_win_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bram_we    = r_we;
  assign bram_addr  = r_addr;
  assign bram_wdata = r_wdata;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_key_sched_bram_writer.sv
// Scoreboard bench for key_sched_bram_writer against an independent
// AES-256 key expansion model (S-box derived from GF(2^8) inverse).
module tb_key_sched_bram_writer;

`ifdef DEC_KEY_SCHED_EN
  localparam int  NW  = 120;
  localparam bit  DEC = 1'b1;
`else
  localparam int  NW  = 60;
  localparam bit  DEC = 1'b0;
`endif

  localparam logic [255:0] K1 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [255:0] key_in = '0;
  logic         bram_we;
  logic [7:0]   bram_addr;
  logic [31:0]  bram_wdata;
  logic         busy;
  logic         done;

  key_sched_bram_writer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_in     (key_in),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [7:0]  sbox_m [256];
  logic [7:0]  rcon_m [8];
  logic [31:0] m_w [60];

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] rc;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^
                  rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rc = 8'h01;
    rcon_m[0] = 8'h00;
    for (int j = 1; j < 8; j++) begin
      rcon_m[j] = rc;
      rc = gmul(rc, 8'h02);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbox_m[v[31:24]], sbox_m[v[23:16]],
            sbox_m[v[15:8]], sbox_m[v[7:0]]};
  endfunction

  task automatic build_model(input logic [255:0] k);
    logic [31:0] t;
    for (int i = 0; i < 60; i++) begin
      if (i < 8) begin
        m_w[i] = k[255-32*i -: 32];
      end else begin
        t = m_w[i-1];
        if (i % 8 == 0)
          t = subw({t[23:0], t[31:24]}) ^ {rcon_m[i/8], 24'h0};
        else if (i % 8 == 4)
          t = subw(t);
        m_w[i] = m_w[i-8] ^ t;
      end
    end
  endtask

  logic [39:0] sb [$];
  int          n_push = 0;
  int          n_wr = 0;
  logic [31:0] mem [256];
  int          wcnt [256];

  task automatic push_run();
    for (int i = 0; i < 60; i++) begin
      sb.push_back({8'(i), m_w[i]});
      n_push++;
      if (DEC) begin
        sb.push_back({8'(60 + 4 * (14 - i / 4) + i % 4), m_w[i]});
        n_push++;
      end
    end
  endtask

  task automatic clear_log();
    for (int a = 0; a < 256; a++) begin
      wcnt[a] = 0;
      mem[a]  = 32'h0;
    end
  endtask

  always @(negedge clk) begin
    if (rst && bram_we) begin
      n_wr++;
      wcnt[bram_addr]++;
      mem[bram_addr] = bram_wdata;
      if (sb.size() == 0)
        chk("unexp_wr", 64'(n_wr), 64'(n_push));
      else
        chk("wr", 64'({bram_addr, bram_wdata}), 64'(sb.pop_front()));
    end
  end

  task automatic pulse_start(input logic [255:0] k, output int t0);
    @(posedge clk);
    #2 key_in = k;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int t0, output int lat);
    bit seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", 64'(seen), 64'd1);
    lat = cyc - t0 + 1;
  endtask

  task automatic check_run(input string tag);
    int bad = 0;
    int sum = 0;
    int e;
    for (int a = 0; a < 256; a++) begin
      e = (a < 60) ? 1 : ((DEC && a < 120) ? 1 : 0);
      if (wcnt[a] != e) bad++;
      sum += wcnt[a];
    end
    chk({tag, "_cover"}, 64'(bad), 64'd0);
    chk({tag, "_nwr"}, 64'(sum), 64'(NW));
    chk({tag, "_sb_left"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_we"}, 64'(bram_we), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int lat;
    int d1;
    int gap;
    bit seen;

    build_tables();

    #12;
    check_idle_outputs("rst");
    chk("rst_addr", 64'(bram_addr), 64'd0);
    chk("rst_wdata", 64'(bram_wdata), 64'd0);
    @(posedge clk);
    #2 rst = 1'b1;

    // FIPS-197 C.3 key
    build_model(K1);
    clear_log();
    push_run();
    pulse_start(K1, t0);
    repeat (10) @(negedge clk);
    chk("busy_mid", 64'(busy), 64'd1);
    wait_done(t0, lat);
    chk("done_lat", 64'(lat), 64'(NW + 1));
    chk("a0", 64'(mem[0]), 64'h00010203);
    chk("a7", 64'(mem[7]), 64'h1c1d1e1f);
    chk("a8", 64'(mem[8]), 64'ha573c29f);
    chk("a56", 64'(mem[56]), 64'h24fc79cc);
    chk("a59", 64'(mem[59]), 64'h6d68de36);
    if (DEC) begin
      chk("a60", 64'(mem[60]), 64'h24fc79cc);
      chk("a63", 64'(mem[63]), 64'h6d68de36);
      chk("a116", 64'(mem[116]), 64'h00010203);
      chk("a119", 64'(mem[119]), 64'h0c0d0e0f);
    end
    chk("done_busy", 64'(busy), 64'd0);
    chk("hold_addr", 64'(bram_addr), DEC ? 64'd63 : 64'd59);
    chk("hold_data", 64'(bram_wdata), 64'h6d68de36);
    @(negedge clk);
    check_idle_outputs("post_done");
    check_run("r1");

    // start and key_in changes while busy
    clear_log();
    push_run();
    pulse_start(K1, t0);
    repeat (9) @(posedge clk);
    #2 start = 1'b1;
    key_in = ~K1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (19) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    wait_done(t0, lat);
    chk("ign_lat", 64'(lat), 64'(NW + 1));
    check_run("r2");

    // async reset during write 25
    clear_log();
    push_run();
    pulse_start(K1, t0);
    repeat (24) @(posedge clk);
    #3;
    chk("pre_rst_we", 64'(bram_we), 64'd1);
    chk("pre_rst_addr", 64'(bram_addr), DEC ? 64'd12 : 64'd24);
    rst = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    n_push -= sb.size();
    sb.delete();
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("no_resume");
    clear_log();
    push_run();
    pulse_start(K1, t0);
    wait_done(t0, lat);
    chk("rr_lat", 64'(lat), 64'(NW + 1));
    chk("rr_a0", 64'(mem[0]), 64'h00010203);
    chk("rr_a59", 64'(mem[59]), 64'h6d68de36);
    check_run("r3");

    // all-zero key, start held high for two runs
    build_model(256'h0);
    clear_log();
    push_run();
    push_run();
    @(posedge clk);
    #2 key_in = 256'h0;
    start = 1'b1;
    @(posedge clk);
    #2 t0 = cyc;
    wait_done(t0, lat);
    chk("b2b_lat1", 64'(lat), 64'(NW + 1));
    chk("zk_a8", 64'(mem[8]), 64'h62636363);
    chk("zk_a59", 64'(mem[59]), 64'(m_w[59]));
    d1 = cyc;
    clear_log();
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (bram_we) seen = 1'b1;
    end
    gap = cyc - d1;
    chk("b2b_gap", 64'(gap), 64'd2);
    t0 = cyc;
    wait_done(t0, lat);
    start = 1'b0;
    chk("b2b_lat2", 64'(lat), 64'(NW + 1));
    chk("zk2_a8", 64'(mem[8]), 64'h62636363);
    chk("zk2_a59", 64'(mem[59]), 64'(m_w[59]));
    check_run("r4");
    repeat (5) @(negedge clk);
    check_idle_outputs("no_third");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
